sha_msg_feeder: RTL

- Message-side initiator for the SHA-256 compression core.
- Accepts a byte message as a stream of big-endian 32-bit words and assembles 512-bit blocks.
- Applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit-length) and drives each block into the core with the chaining value.
- Sequences the core's start/done/reset handshake and presents the final 256-bit digest.

---
 rtl/sha_pkg.sv | 24 ++
 rtl/sha_pad_word.sv | 26 ++
 rtl/sha_msg_feeder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 message feeder.
//   SHA_IV         : SHA-256 initial hash value, H0 in [31:0] ... H7 in [255:224]
//   CORE_START     : code driven on core_start to launch one compression
//   state_t        : feeder FSM state encoding (also visible on dbg_state)
package sha_pkg;

  localparam logic [255:0] SHA_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [7:0] CORE_START = 8'd17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_PAD    = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_CLEAR  = 3'd5,
    S_EMIT   = 3'd6
  } state_t;

endpackage

// File: rtl/sha_pad_word.sv
// Last-word masking for the message feeder.
//   data         : final message word, first byte in [31:24]
//   n_bytes      : valid bytes in data (0..4, left-aligned; 5..7 behave as 4)
//   padded       : data with unused bytes cleared and 0x80 placed after the
//                  last valid byte; equals data when the word is full
//   needs_marker : word was full, so the 0x80 byte must go in the next word
module sha_pad_word (
  input  logic [31:0] data,
  input  logic [2:0]  n_bytes,
  output logic [31:0] padded,
  output logic        needs_marker
);

  always_comb begin
    padded       = data;
    needs_marker = 1'b0;
    case (n_bytes)
      3'd0:    padded = 32'h8000_0000;
      3'd1:    padded = {data[31:24], 24'h80_0000};
      3'd2:    padded = {data[31:16], 16'h8000};
      3'd3:    padded = {data[31:8], 8'h80};
      default: needs_marker = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha_msg_feeder.sv
// Message-side initiator for a SHA-256 compression core.
// Collects big-endian 32-bit message words into a 16-word block buffer,
// applies SHA-256 padding, launches the core once per block with the running
// chaining value, and presents the final digest.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready/in_last/in_bytes : message word stream
//   core_start/core_block/core_h_in/core_reset : core command side
//   core_done/core_h_out  : core result side
//   digest/digest_valid   : final hash (H0 in [31:0]) and its update pulse
//   busy                  : a message is in flight
//   dbg_state             : current FSM state (sha_pkg::state_t encoding)
// Handshake: a word transfers on every rising clk edge where in_valid and
// in_ready are both high; a source presenting in_valid while in_ready is low
// must hold the word unchanged until it transfers.
module sha_msg_feeder
  import sha_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic [7:0]   core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_h_in,
  output logic         core_reset,
  input  logic         core_done,
  input  logic [255:0] core_h_out,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  localparam logic [LEN_W-1:0] FOUR = LEN_W'(4);

  state_t             state, state_d;
  logic [31:0]        blk [16];
  logic [4:0]         widx;
  logic [LEN_W-1:0]   byte_cnt;
  logic [255:0]       chain;
  logic               need_80;     // 0x80 marker not yet written
  logic               pad_pending; // message ended, padding not finished
  logic               pad_done;    // length field written into the buffer
  logic               clear_pulse;
  logic               accept;
  logic [31:0]        last_word;
  logic               last_full;
  logic [2:0]         in_k;
  logic [LEN_W-1:0]   k_ext;
  logic [63:0]        bit_len;
  logic [3:0]         wr_idx;

  sha_pad_word u_pad (
    .data         (in_data),
    .n_bytes      (in_bytes),
    .padded       (last_word),
    .needs_marker (last_full)
  );

  assign in_k    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign k_ext   = {{(LEN_W-3){1'b0}}, in_k};
  assign bit_len = {{(61-LEN_W){1'b0}}, byte_cnt, 3'b000};
  assign accept  = in_valid & in_ready;
  // The first word of a message always lands in slot 0.
  assign wr_idx  = (state == S_IDLE) ? 4'd0 : widx[3:0];

  assign core_h_in  = chain;
  assign core_reset = ~reset_n | clear_pulse;
  assign busy       = (state != S_IDLE) && (state != S_EMIT);
  assign dbg_state  = state;

  always_comb begin
    core_block = '0;
    for (int i = 0; i < 16; i++) core_block[511-32*i -: 32] = blk[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d     = state;
    in_ready    = 1'b0;
    core_start  = 8'd0;
    clear_pulse = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? S_PAD : S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)            state_d = S_PAD;
          else if (widx == 5'd15) state_d = S_LAUNCH;
        end
      end
      S_PAD: begin
        // Launch once the buffer is full: either the length went into
        // words 14-15 this cycle, or slot 15 is being (or was) filled.
        if (widx == 5'd16 || widx == 5'd15 || (widx == 5'd14 && !need_80))
          state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        core_start = CORE_START;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear_pulse = 1'b1;
        if (pad_done)         state_d = S_EMIT;
        else if (pad_pending) state_d = S_PAD;
        else                  state_d = S_FILL;
      end
      S_EMIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) blk[i] <= '0;
      widx         <= '0;
      byte_cnt     <= '0;
      chain        <= SHA_IV;
      digest       <= '0;
      digest_valid <= 1'b0;
      need_80      <= 1'b0;
      pad_pending  <= 1'b0;
      pad_done     <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            blk[wr_idx] <= in_last ? last_word : in_data;
            widx        <= {1'b0, wr_idx} + 5'd1;
            pad_pending <= in_last;
            need_80     <= in_last & last_full;
            pad_done    <= 1'b0;
            if (state == S_IDLE) begin
              chain    <= SHA_IV;
              byte_cnt <= in_last ? k_ext : FOUR;
            end else begin
              byte_cnt <= byte_cnt + (in_last ? k_ext : FOUR);
            end
          end
        end
        S_PAD: begin
          if (widx != 5'd16) begin
            if (need_80) begin
              blk[widx[3:0]] <= 32'h8000_0000;
              need_80        <= 1'b0;
              widx           <= widx + 5'd1;
            end else if (widx == 5'd14) begin
              blk[14]  <= bit_len[63:32];
              blk[15]  <= bit_len[31:0];
              pad_done <= 1'b1;
              widx     <= 5'd16;
            end else begin
              blk[widx[3:0]] <= '0;
              widx           <= widx + 5'd1;
            end
          end
        end
        S_WAIT: begin
          if (core_done) chain <= core_h_out;
        end
        S_CLEAR: begin
          widx <= '0;
          // Load the digest on the way into EMIT so it is already valid
          // while digest_valid is high.
          if (pad_done) begin
            digest       <= chain;
            digest_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          chain       <= SHA_IV;
          byte_cnt    <= '0;
          pad_pending <= 1'b0;
          pad_done    <= 1'b0;
          need_80     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
